// File: rtl/prog_mem_arb.sv
// prog_mem_arb: shared program memory with one synchronous read port arbitrated
// round-robin among NCORE fetch requesters, a loader write port with a
// valid/ready handshake, and a clear engine that fills the array with CLR_WORD.
// Loader writes take absolute priority over fetches, so the array never sees a
// read and a write in the same cycle.
module prog_mem_arb #(
  parameter int              DW         = 18,
  parameter int              AW         = 12,
  parameter int              NCORE      = 4,
  parameter logic [DW-1:0]   CLR_WORD   = {DW{1'b0}},
  parameter bit              CLR_ON_RST = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NCORE-1:0]    FREQ,
  input  logic [NCORE*AW-1:0] FA,
  output logic [NCORE-1:0]    FACK,
  output logic [NCORE-1:0]    FVALID,
  output logic [DW-1:0]       FDQ,
  input  logic                LD_VALID,
  output logic                LD_READY,
  input  logic [AW-1:0]       LD_A,
  input  logic [DW-1:0]       LD_DI,
  input  logic                LOCK,
  input  logic                CLR_START,
  output logic                BUSY
);

  localparam int DEPTH = 1 << AW;
  localparam int PW    = (NCORE > 1) ? $clog2(NCORE) : 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NCORE-1:0]  fvalid_q;
  logic [DW-1:0]     fdq_q;
  logic [DW-1:0]     mem_q [DEPTH];

  logic              gnt_any_s;
  logic [PW-1:0]     gnt_idx_s;
  logic [PW-1:0]     cand_s;
  logic              gnt_en_s;
  logic [NCORE-1:0]  fack_s;
  logic [AW-1:0]     rd_addr_s;
  logic              ld_ready_s;
  logic              busy_s;
  logic              mem_we_s;
  logic [AW-1:0]     mem_wa_s;
  logic [DW-1:0]     mem_wd_s;

  // Round-robin search: first requesting core at or after the pointer, wrapping.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    cand_s    = '0;
    for (int k = 0; k < NCORE; k++) begin
      cand_s = PW'((int'(ptr_q) + k) % NCORE);
      if (!gnt_any_s && FREQ[cand_s]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = cand_s;
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
  end

  // A grant is issued only in RUN, outside reset, and when no loader write is accepted.
  assign gnt_en_s  = ~RST & (state_q == ST_RUN) & ~(LD_VALID & ~LOCK) & gnt_any_s;
  assign rd_addr_s = FA[gnt_idx_s*AW +: AW];

  // One-hot grant and next round-robin pointer (grant+1, wrapping).
  always_comb begin
    fack_s = '0;
    ptr_d  = ptr_q;
    if (gnt_en_s) begin
      fack_s[gnt_idx_s] = 1'b1;
      if (gnt_idx_s == PW'(NCORE - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_s + PW'(1);
      end
    end else begin
      fack_s = '0;
      ptr_d  = ptr_q;
    end
  end

  // Mode FSM next state, clear counter and array write-port selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_ready_s = 1'b0;
    busy_s     = 1'b0;
    mem_we_s   = 1'b0;
    mem_wa_s   = LD_A;
    mem_wd_s   = LD_DI;
    case (state_q)
      ST_RUN: begin
        ld_ready_s = ~LOCK;
        mem_we_s   = ~RST & ~LOCK & LD_VALID;
        if (CLR_START) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_CLEAR: begin
        busy_s   = 1'b1;
        mem_we_s = ~RST;
        mem_wa_s = cnt_q;
        mem_wd_s = CLR_WORD;
        cnt_d    = cnt_q + AW'(1);
        if (cnt_q == {AW{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign LD_READY = ~RST & ld_ready_s;
  assign BUSY     = RST ? CLR_ON_RST : busy_s;
  assign FACK     = fack_s;
  assign FVALID   = fvalid_q;
  assign FDQ      = fdq_q;

  // State, clear counter and arbitration pointer registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLR_ON_RST ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Array write port shared by the loader and the clear engine; no reset on contents.
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_q[mem_wa_s] <= mem_wd_s;
    end
  end

  // Registered fetch data; FDQ holds when there is no grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fvalid_q <= '0;
      fdq_q    <= '0;
    end else begin
      fvalid_q <= fack_s;
      if (gnt_en_s) begin
        fdq_q <= mem_q[rd_addr_s];
      end
    end
  end

endmodule

// File: tb/tb_prog_mem_arb.sv
// Directed bench for prog_mem_arb with default parameters (DW=18, AW=12, NCORE=4).
module tb_prog_mem_arb;

  localparam int DW    = 18;
  localparam int AW    = 12;
  localparam int NCORE = 4;

  logic                clk;
  logic                rst;
  logic [NCORE-1:0]    freq;
  logic [NCORE*AW-1:0] fa;
  logic [NCORE-1:0]    fack;
  logic [NCORE-1:0]    fvalid;
  logic [DW-1:0]       fdq;
  logic                ld_valid;
  logic                ld_ready;
  logic [AW-1:0]       ld_a;
  logic [DW-1:0]       ld_di;
  logic                lock;
  logic                clr_start;
  logic                busy;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_n;
  int busy_bad;

  prog_mem_arb dut (
    .CLK(clk), .RST(rst), .FREQ(freq), .FA(fa), .FACK(fack), .FVALID(fvalid),
    .FDQ(fdq), .LD_VALID(ld_valid), .LD_READY(ld_ready), .LD_A(ld_a),
    .LD_DI(ld_di), .LOCK(lock), .CLR_START(clr_start), .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts cycles with BUSY high (sampled mid-cycle); bounded at 5000.
  task automatic count_busy(output int n, output int bad);
    n   = 0;
    bad = 0;
    while (busy && n < 5000) begin
      if (ld_ready !== 1'b0 || fack !== '0) bad++;
      n++;
      @(posedge clk); #2;
    end
  endtask

  // Single-core fetch starting just after an edge; ends just after the edge that follows FVALID.
  task automatic fetch_one(input int core, input logic [AW-1:0] addr,
                           input logic [DW-1:0] expd, input string tag);
    freq = 4'b0001 << core;
    fa[core*AW +: AW] = addr;
    #1;
    check({tag, "_fack"}, fack, 4'b0001 << core);
    @(posedge clk); #1;
    freq = '0;
    #1;
    check({tag, "_fvalid"}, fvalid, 4'b0001 << core);
    check({tag, "_fdq"}, fdq, expd);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; freq = '0; fa = '0; ld_valid = 1'b0; ld_a = '0; ld_di = '0;
    lock = 1'b0; clr_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, with requests present that must be masked
    freq = 4'hF; ld_valid = 1'b1; ld_a = 12'h007; ld_di = 18'h15555;
    #1;
    check("rst_busy", busy, 1'b1);
    check("rst_ldready", ld_ready, 1'b0);
    check("rst_fack", fack, 4'b0000);
    check("rst_fvalid", fvalid, 4'b0000);
    check("rst_fdq", fdq, 18'h00000);

    // Power-on clear: DEPTH cycles, no loader accepts or grants throughout
    rst = 1'b0;
    #1;
    count_busy(busy_n, busy_bad);
    check("clr_len", busy_n, 4096);
    check("clr_quiet", busy_bad, 0);
    freq = '0; ld_valid = 1'b0;
    @(posedge clk); #1;

    fetch_one(0, 12'h000, 18'h00000, "clr_lo");            // ptr -> 1

    // Loader write concurrent with a request: write wins, FACK=0
    ld_valid = 1'b1; ld_a = 12'h005; ld_di = 18'h00A42;
    freq = 4'b0100; fa[2*AW +: AW] = 12'h005;
    #1;
    check("wr_ready", ld_ready, 1'b1);
    check("wr_fack", fack, 4'b0000);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    fetch_one(2, 12'h005, 18'h00A42, "wr_rd");             // ptr -> 3
    #1;
    check("hold_fvalid", fvalid, 4'b0000);
    check("hold_fdq", fdq, 18'h00A42);

    // Locked write is refused and does not block fetches
    lock = 1'b1; ld_valid = 1'b1; ld_a = 12'h005; ld_di = 18'h3FFFF;
    freq = 4'b0010; fa[1*AW +: AW] = 12'h005;
    #1;
    check("lock_ready", ld_ready, 1'b0);
    check("lock_fack", fack, 4'b0010);
    @(posedge clk); #1;
    ld_valid = 1'b0; lock = 1'b0; freq = '0;
    #1;
    check("lock_fvalid", fvalid, 4'b0010);
    check("lock_fdq", fdq, 18'h00A42);
    @(posedge clk); #1;

    fetch_one(3, 12'hFFF, 18'h00000, "clr_hi");            // ptr -> 0

    // All cores requesting: rotating grants, FVALID one cycle behind
    for (int c = 0; c < NCORE; c++) fa[c*AW +: AW] = 12'h005;
    freq = 4'hF;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) freq = '0;
      #1;
      if (k < 8) check($sformatf("rr_fack%0d", k), fack, 1 << (k % 4));
      if (k > 0) check($sformatf("rr_fvalid%0d", k), fvalid, 1 << ((k - 1) % 4));
      if (k == 3) check("rr_fdq", fdq, 18'h00A42);
      @(posedge clk); #1;
    end

    fetch_one(1, 12'h007, 18'h00000, "clr_sup");           // ptr -> 2

    // Loader starves cores 0/1 for 3 cycles, then pointer-ordered grants resume
    freq = 4'b0011; fa[0*AW +: AW] = 12'h010; fa[1*AW +: AW] = 12'h011;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_a = AW'(12'h010 + i); ld_di = DW'(18'h11111 * (i + 1));
      #1;
      check($sformatf("ld_ready%0d", i), ld_ready, 1'b1);
      check($sformatf("ld_fack%0d", i), fack, 4'b0000);
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    #1;
    check("ld_first_gnt", fack, 4'b0001);
    @(posedge clk); #2;
    check("ld_second_gnt", fack, 4'b0010);
    check("ld_fvalid0", fvalid, 4'b0001);
    check("ld_fdq0", fdq, 18'h11111);
    @(posedge clk); #1;
    freq = '0;
    #1;
    check("ld_fvalid1", fvalid, 4'b0010);
    check("ld_fdq1", fdq, 18'h22222);
    @(posedge clk); #1;
    fetch_one(2, 12'h012, 18'h33333, "ld3");               // ptr -> 3

    // Clear request during an active fetch, then reset 100 cycles into the clear
    freq = 4'b1000; fa[3*AW +: AW] = 12'h010; clr_start = 1'b1;
    #1;
    check("cs_fack", fack, 4'b1000);
    check("cs_busy0", busy, 1'b0);
    @(posedge clk); #1;
    clr_start = 1'b0; freq = '0;
    #1;
    check("cs_fvalid", fvalid, 4'b1000);
    check("cs_fdq", fdq, 18'h11111);
    check("cs_busy1", busy, 1'b1);
    check("cs_ldready", ld_ready, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    count_busy(busy_n, busy_bad);
    check("reclr_len", busy_n, 4096);
    check("reclr_quiet", busy_bad, 0);
    @(posedge clk); #1;
    fetch_one(0, 12'h005, 18'h00000, "reclr_5");
    fetch_one(1, 12'h010, 18'h00000, "reclr_10");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
